// File: rtl/fact_cu_pkg.sv
// Shared definitions for the factorial control unit and its datapath top:
// state encoding and the control-word bit positions.
package fact_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_MULT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  // Control-word bit positions, also used by the datapath top to unpack.
  localparam int LOAD_CNT = 0;
  localparam int EN_CNT   = 1;
  localparam int LOAD_REG = 2;
  localparam int SEL      = 3;
  localparam int OE       = 4;
  localparam int CW_W     = 5;

endpackage

// File: rtl/fact_cu_if.sv
// Control-unit <-> wrapper/datapath bundle. The master side raises go and
// reports datapath status; the slave (the control unit) drives the controls.
interface fact_cu_if;
  logic       go;
  logic       gt;
  logic       n_gt12;
  logic       load_cnt;
  logic       en_cnt;
  logic       load_reg;
  logic       sel;
  logic       oe;
  logic       done;
  logic       err;
  logic [2:0] cs;

  modport master (
    output go, gt, n_gt12,
    input  load_cnt, en_cnt, load_reg, sel, oe, done, err, cs
  );

  modport slave (
    input  go, gt, n_gt12,
    output load_cnt, en_cnt, load_reg, sel, oe, done, err, cs
  );
endinterface

// File: rtl/fact_cu_wdt.sv
// Watchdog for the CHECK/MULT loop: counts cycles spent looping and flags a
// trip on the cycle that would exceed the allowed WD_LIMIT cycles.
module fact_cu_wdt #(
  parameter int WD_LIMIT = 64,
  parameter int WD_WIDTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic trip
);

  logic [WD_WIDTH-1:0] cnt;

  // Cycle counter: cleared before a computation, advanced while looping,
  // held otherwise (DONE/ERROR).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + WD_WIDTH'(1);
  end

  // cnt counts completed loop cycles, so the current one is the
  // WD_LIMIT-th when cnt == WD_LIMIT-1; leave on the next edge.
  assign trip = inc && (cnt == WD_WIDTH'(WD_LIMIT - 1));

endmodule

// File: rtl/fact_cu.sv
// Moore control unit for the factorial datapath. Sequences counter load,
// multiply loop and result enable from the gt / n_gt12 status flags, with a
// level go/done handshake. Define FACT_CU_WATCHDOG_EN to add a loop
// watchdog (and the WD_LIMIT / WD_WIDTH parameters) that forces ERROR.
module fact_cu
  import fact_pkg::*;
`ifdef FACT_CU_WATCHDOG_EN
  #(
    parameter int WD_LIMIT = 64,
    parameter int WD_WIDTH = 7
  )
`endif
  (
    input  logic       clk,
    input  logic       rst,
    fact_cu_if.slave   bus
  );

  state_t            state, state_nxt;
  logic [CW_W-1:0]   cw;
  logic              done_d, err_d;

`ifdef FACT_CU_WATCHDOG_EN
  logic wd_trip;

  fact_cu_wdt #(
    .WD_LIMIT (WD_LIMIT),
    .WD_WIDTH (WD_WIDTH)
  ) u_wdt (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == S_IDLE) || (state == S_INIT)),
    .inc  ((state == S_CHECK) || (state == S_MULT)),
    .trip (wd_trip)
  );
`endif

  // State register; reset lands in IDLE without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore output decode; illegal codes fall back to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    cw        = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.go) state_nxt = bus.n_gt12 ? S_ERROR : S_INIT;
        else        state_nxt = S_IDLE;
      end
      S_INIT: begin
        cw[LOAD_CNT] = 1'b1;
        cw[LOAD_REG] = 1'b1;
        state_nxt    = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = bus.gt ? S_MULT : S_DONE;
      end
      S_MULT: begin
        cw[LOAD_REG] = 1'b1;
        cw[SEL]      = 1'b1;
        cw[EN_CNT]   = 1'b1;
        state_nxt    = S_CHECK;
      end
      S_DONE: begin
        done_d    = 1'b1;
        cw[OE]    = 1'b1;
        state_nxt = bus.go ? S_DONE : S_IDLE;
      end
      S_ERROR: begin
        err_d     = 1'b1;
        state_nxt = bus.go ? S_ERROR : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef FACT_CU_WATCHDOG_EN
    if (wd_trip) state_nxt = S_ERROR;
`endif
  end

  assign bus.load_cnt = cw[LOAD_CNT];
  assign bus.en_cnt   = cw[EN_CNT];
  assign bus.load_reg = cw[LOAD_REG];
  assign bus.sel      = cw[SEL];
  assign bus.oe       = cw[OE];
  assign bus.done     = done_d;
  assign bus.err      = err_d;
  assign bus.cs       = state;

endmodule

// File: tb/tb_fact_cu.sv
// Directed bench for fact_cu with a behavioural counter/product datapath.
module tb_fact_cu;

  logic        clk;
  logic        rst;
  int          n;
  logic        force_gt;
  logic [31:0] cnt, prod;
  logic [6:0]  outs;
  int          n_pass, n_total;

  fact_cu_if bus ();

  fact_cu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: down-counter, product register, mux 1 / prod*cnt.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 32'd0;
      prod <= 32'd0;
    end else begin
      if (bus.load_cnt)    cnt <= n;
      else if (bus.en_cnt) cnt <= cnt - 32'd1;
      if (bus.load_reg)    prod <= bus.sel ? prod * cnt : 32'd1;
    end
  end

  assign bus.gt     = force_gt | (cnt > 32'd1);
  assign bus.n_gt12 = (n > 12);
  assign outs = {bus.load_cnt, bus.en_cnt, bus.load_reg, bus.sel,
                 bus.oe, bus.done, bus.err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // go held through the whole computation; edges counted from E0 (k=0).
  task automatic run_fact(input int nv, input int exp_res, input int exp_edges,
                          input int exp_mults, input string tag);
    int mults;
    int edges;
    mults = 0;
    edges = -1;
    n = nv;
    bus.go = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (k == 0) begin
        chk({tag, " cs@E0"}, 32'(bus.cs), 32'd1);
        chk({tag, " ctl@E0"}, 32'({bus.load_cnt, bus.load_reg, bus.sel}), 32'b110);
      end
      if (bus.en_cnt) mults++;
      if (bus.done) begin
        edges = k;
        break;
      end
    end
    chk({tag, " done_edge"}, 32'(edges), 32'(exp_edges));
    chk({tag, " mults"}, 32'(mults), 32'(exp_mults));
    chk({tag, " result"}, bus.oe ? prod : 32'hdead, 32'(exp_res));
    tick();
    chk({tag, " done_held"}, 32'(bus.cs), 32'd4);
    bus.go = 1'b0;
    tick();
    chk({tag, " back_idle"}, 32'(bus.cs), 32'd0);
    chk({tag, " idle_outs"}, 32'(outs), 32'd0);
  endtask

  initial begin
    int bad;
    int mults;
    int err_k;
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    n        = 0;
    force_gt = 1'b0;
    bus.go   = 1'b0;

    // Reset state
    #2;
    chk("reset cs", 32'(bus.cs), 32'd0);
    chk("reset outs", 32'(outs), 32'd0);
    #10 rst = 1'b0;

    // Idle with go low for 10 cycles
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.cs != 3'd0 || outs != 7'd0) bad++;
    end
    chk("idle 10", 32'(bad), 32'd0);

    run_fact(5, 120, 10, 4, "n5");
    run_fact(0, 1, 2, 0, "n0");
    run_fact(1, 1, 2, 0, "n1");
    run_fact(3, 6, 6, 2, "n3");

    // go dropped right after E0: computation still finishes, done shown once
    n = 1;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    chk("short go done", 32'(bus.done), 32'd1);
    tick();
    chk("short go idle", 32'(bus.cs), 32'd0);

    // Out-of-range input
    n = 13;
    bus.go = 1'b1;
    tick();
    chk("n13 cs", 32'(bus.cs), 32'd5);
    chk("n13 outs", 32'(outs), 32'd1);
    tick();
    tick();
    tick();
    chk("n13 err held", 32'(bus.err), 32'd1);
    bus.go = 1'b0;
    tick();
    chk("n13 idle", 32'(bus.cs), 32'd0);

    // Async reset during the third MULT, then restart with go still high
    n = 6;
    bus.go = 1'b1;
    mults = 0;
    for (int k = 0; k < 50 && mults < 3; k++) begin
      tick();
      if (bus.en_cnt) mults++;
    end
    chk("n6 reached mult3", 32'(mults), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("midrst cs", 32'(bus.cs), 32'd0);
    chk("midrst outs", 32'(outs), 32'd0);
    #2 rst = 1'b0;
    run_fact(6, 720, 12, 5, "n6 restart");

    // Runaway loop: gt forced high
    n = 3;
    force_gt = 1'b1;
    bus.go = 1'b1;
    bad = 0;
    err_k = -1;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (bus.err && err_k < 0) err_k = k;
`ifndef FACT_CU_WATCHDOG_EN
      if (bus.err || (k > 0 && bus.cs != 3'd2 && bus.cs != 3'd3)) bad++;
`endif
    end
`ifdef FACT_CU_WATCHDOG_EN
    chk("wdt err edge", 32'(err_k), 32'd65);
    chk("wdt err held", 32'(bus.cs), 32'd5);
    bus.go = 1'b0;
    tick();
    chk("wdt idle", 32'(bus.cs), 32'd0);
`else
    chk("runaway no err", 32'(bad), 32'd0);
`endif
    force_gt = 1'b0;
    bus.go = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("final rst cs", 32'(bus.cs), 32'd0);
    #2 rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fact_cu.md
Name: fact_cu

Overview:
Control unit for the Lab1 factorial datapath (down-counter, product register, result mux, CMP magnitude comparators).
Moore FSM that sequences the datapath using two status flags:
- gt: count > 1, from a CMP instance.
- n_gt12: input n > 12, from a second CMP instance; signals overflow.
Implements a level go/done handshake toward the top-level wrapper.

Parameters:
WD_LIMIT, 64, max cycles allowed in CHECK/MULT before watchdog error (FACT_CU_WATCHDOG_EN only)
WD_WIDTH, 7, watchdog counter width; must satisfy 2^WD_WIDTH > WD_LIMIT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
go  input  1  start request; level, held by requester until done/err seen
gt  input  1  datapath status: counter value > 1
n_gt12  input  1  datapath status: n > 12
load_cnt  output  1  load counter with n
en_cnt  output  1  decrement counter
load_reg  output  1  write product register
sel  output  1  product mux select: 0 = constant 1, 1 = multiplier output
oe  output  1  result output buffer enable
done  output  1  result valid
err  output  1  input out of range (or watchdog trip)
cs  output  3  current state, for debug/LEDs

Behaviour:
- One clock; reset is asynchronous and active-high.
- rst high: state forced to IDLE immediately, not waiting for clk. Watchdog cleared.
- All outputs are decoded from the state register only (Moore). At reset every output is 0 and cs = IDLE.
- States and outputs:
  - IDLE: all outputs 0.
  - INIT: load_cnt=1, load_reg=1, sel=0.
  - CHECK: all outputs 0.
  - MULT: load_reg=1, sel=1, en_cnt=1.
  - DONE: done=1, oe=1.
  - ERROR: err=1.
- Transitions:
  - IDLE: go & n_gt12 -> ERROR. go & !n_gt12 -> INIT. Otherwise stay. Error has priority.
  - INIT -> CHECK, unconditional.
  - CHECK: gt -> MULT, else -> DONE.
  - MULT -> CHECK, unconditional.
  - DONE: stay while go=1; go=0 -> IDLE. done is high for at least one cycle even if go already dropped.
  - ERROR: stay while go=1; go=0 -> IDLE.
- go dropping during INIT/CHECK/MULT is ignored; the computation completes.
- Latency, counted from the edge E0 that samples go=1 in IDLE:
  - INIT after E0, first CHECK after E1.
  - MULT visited n-1 times for n >= 2.
  - DONE after edge E(2n) for n >= 1; after E2 for n = 0 or 1.
  - ERROR after E0.
- n_gt12 is sampled only in IDLE and ignored elsewhere.
- gt is sampled only in CHECK.
- State encoding, 3 bits: IDLE=0, INIT=1, CHECK=2, MULT=3, DONE=4, ERROR=5.
- Codes 6 and 7 are illegal: next state = IDLE, outputs 0.

Optional Feature:
Macro FACT_CU_WATCHDOG_EN.
- Defined:
  - A WD_WIDTH-bit counter clears in IDLE and INIT and increments each cycle in CHECK or MULT.
  - When it reaches WD_LIMIT while in CHECK or MULT, next state = ERROR, overriding the normal transition.
  - The counter is reset asynchronously by rst.
- Not defined: no counter logic, WD_LIMIT/WD_WIDTH unused, ERROR reachable only via n_gt12.

Decomposition:
- Package fact_pkg: 3-bit state localparams (S_IDLE..S_ERROR), and the control-word bit positions shared with the datapath top (LOAD_CNT, EN_CNT, LOAD_REG, SEL, OE).
- One sub-module, fact_cu_wdt (watchdog counter plus compare, trip output), instantiated only under FACT_CU_WATCHDOG_EN.
- Next-state and output decode stay in fact_cu.

Test Plan:
- Reset then idle: rst pulsed mid-cycle -> cs=0 and all outputs 0 before the next clk edge; with go=0, stays IDLE for 10 cycles.
- n=5 with behavioural datapath model: go held -> load_cnt pulse after E0; 4 MULT pulses; done=1 after E10, model result 120; go released -> IDLE next edge.
- n=0 and n=1: done after E2, zero MULT cycles, result 1.
- n=13 (n_gt12=1) with go: err=1 after E0, no load_cnt/load_reg pulse; err held while go=1; IDLE one edge after go=0.
- Reset mid-operation: n=6, rst asserted during third MULT -> outputs 0 immediately; after rst release with go=1, restarts from INIT and produces 720.
- Watchdog (macro defined): gt forced to 1 -> err asserts WD_LIMIT=64 cycles after first CHECK. Macro undefined: same stimulus loops CHECK/MULT indefinitely, err stays 0.
